mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the single physical-memory port between the instruction cache and the data cache.
- Sits directly downstream of both caches' pmem interfaces and upstream of the cacheline adaptor / main memory.
- Whole 256-bit line transactions: one read or one write per grant.
- Supports `hold_arbiter` from the data cache so that a write-back followed by a refill completes as one uninterrupted grant.

Parameters:
size, 256, cache line width in bits (pmem data width)
addr_width, 32, physical address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
icache_pmem_read  in  1  icache line read request
icache_pmem_address  in  addr_width  icache line address
icache_pmem_rdata  out  size  line data to icache
icache_pmem_resp  out  1  icache transaction complete
dcache_pmem_read  in  1  dcache line read request
dcache_pmem_write  in  1  dcache line write request
dcache_pmem_address  in  addr_width  dcache line address
dcache_pmem_wdata  in  size  dcache write line
hold_arbiter  in  1  dcache requests grant retention after current transaction
dcache_pmem_rdata  out  size  line data to dcache
dcache_pmem_resp  out  1  dcache transaction complete
pmem_read  out  1  read command to memory
pmem_write  out  1  write command to memory
pmem_address  out  addr_width  address to memory
pmem_wdata  out  size  write line to memory
pmem_rdata  in  size  line data from memory
pmem_resp  in  1  memory transaction complete

Behaviour:
- Clocking and reset:
  - Single clock `clk`; reset `rst` is synchronous and active-high.
  - Reset: state=IDLE, last_served=ICACHE.
  - Out of reset, all outputs are 0: pmem_read/write, both resps, pmem_address, pmem_wdata, both rdata.
- States: IDLE, I_BUSY, D_BUSY. All outputs are combinational from the state and inputs.
- IDLE:
  - No pmem command is driven; all outputs are 0.
  - Requests are sampled here:
    - Only icache requesting -> I_BUSY.
    - Only dcache (read|write) requesting -> D_BUSY.
    - Both requesting -> grant the client not in last_served (round-robin). The first tie after reset goes to dcache.
    - Neither requesting -> stay in IDLE.
  - Arbitration costs exactly one cycle. The pmem command first appears the cycle after the request is seen in IDLE.
- I_BUSY:
  - pmem_read = icache_pmem_read, pmem_write = 0.
  - pmem_address = icache_pmem_address.
  - icache_pmem_rdata = pmem_rdata; icache_pmem_resp = pmem_resp (same cycle).
  - dcache_pmem_resp = 0.
  - On pmem_resp: last_served <= ICACHE, next state IDLE.
- D_BUSY:
  - pmem_read/write/address/wdata are driven from the dcache ports.
  - dcache_pmem_rdata/resp are forwarded from pmem; icache_pmem_resp = 0.
  - On pmem_resp with hold_arbiter=0: last_served <= DCACHE, next state IDLE.
  - On pmem_resp with hold_arbiter=1: stay in D_BUSY. The next dcache command is forwarded the following cycle with no IDLE gap, and icache cannot intervene.
  - While in D_BUSY with dcache read=write=0:
    - hold_arbiter=1 -> remain, driving no command.
    - hold_arbiter=0 -> go to IDLE, last_served <= DCACHE.
- Never both pmem_read and pmem_write high. If dcache asserts both (protocol violation), write wins and read is masked.
- Clients hold request, address and wdata stable until their resp. The arbiter does not latch them.
- Both resp outputs are never high in the same cycle.
- A resp is a single-cycle pulse mirroring pmem_resp. After a resp with no hold, the pmem command is low for at least one cycle (the IDLE cycle).
- A request that drops before its grant is simply not served; there is no stored pending bit.
- Reset mid-transaction: state -> IDLE next cycle and pmem commands drop immediately after reset is sampled. A pmem_resp arriving during or after reset is ignored.
- Starvation bound: icache waits at most one dcache grant (including its held chain) plus the IDLE cycle.

Test Plan:
- Lone icache read:
  - Stimulus: icache_pmem_read=1, addr=0x0000_1040; pmem_resp after 5 cycles with rdata=256'hA5...A5.
  - Required: pmem_read rises 1 cycle after request, address 0x0000_1040; icache_pmem_resp=1 for exactly 1 cycle with that rdata; dcache_pmem_resp stays 0.
- Simultaneous requests from reset:
  - Stimulus: icache read 0x100 and dcache read 0x200 in the same cycle.
  - Required: dcache served first (pmem_address=0x200); then IDLE for 1 cycle; then icache served at 0x100.
- Round-robin fairness:
  - Stimulus: both clients request continuously for 4 transactions.
  - Required: grant order D, I, D, I, each separated by exactly one IDLE cycle.
- Held write-back + refill:
  - Stimulus: dcache write 0x300 with hold_arbiter=1; icache requesting throughout. At the write's resp, dcache switches to read 0x400 and drops hold.
  - Required: pmem_read at 0x400 the cycle after the write resp, with no IDLE cycle; icache granted only after the read resp.
- Reset mid-transaction:
  - Stimulus: rst=1 for 1 cycle while in D_BUSY before pmem_resp.
  - Required: next cycle pmem_read=pmem_write=0, state IDLE; a subsequent pmem_resp produces no client resp.
- Read/write collision:
  - Stimulus: dcache asserts read=1 and write=1 to 0x500.
  - Required: pmem_write=1, pmem_read=0, pmem_wdata equals dcache_pmem_wdata.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-client physical-memory arbiter. Grants the single pmem
//               port to either the instruction cache or the data cache for
//               whole-line transactions. Ties are broken round-robin, and the
//               data cache can keep its grant across a write-back + refill
//               pair by asserting hold_arbiter.
// Ports       : clk, rst                        - clock, sync active-high reset
//               icache_pmem_*                   - instruction-cache client side
//               dcache_pmem_*, hold_arbiter     - data-cache client side
//               pmem_*                          - memory / line-adaptor side
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int SIZE       = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction cache
  input  logic                  icache_pmem_read,
  input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
  output logic [SIZE-1:0]       icache_pmem_rdata,
  output logic                  icache_pmem_resp,
  // data cache
  input  logic                  dcache_pmem_read,
  input  logic                  dcache_pmem_write,
  input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
  input  logic [SIZE-1:0]       dcache_pmem_wdata,
  input  logic                  hold_arbiter,
  output logic [SIZE-1:0]       dcache_pmem_rdata,
  output logic                  dcache_pmem_resp,
  // physical memory
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [SIZE-1:0]       pmem_wdata,
  input  logic [SIZE-1:0]       pmem_rdata,
  input  logic                  pmem_resp
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_I_BUSY = 2'd1;
  localparam logic [1:0] c_D_BUSY = 2'd2;

  localparam logic c_ICACHE = 1'b0;
  localparam logic c_DCACHE = 1'b1;

  logic [1:0] r_state;
  logic       r_last_served;
  logic [1:0] w_state_nxt;
  logic       w_last_nxt;
  logic [1:0] w_out_state;
  logic       w_i_req;
  logic       w_d_req;

  assign w_i_req = icache_pmem_read;
  assign w_d_req = dcache_pmem_read | dcache_pmem_write;

  // Outputs are decoded as if in IDLE while reset is asserted, so a pmem_resp
  // landing in the reset cycle never reaches a client.
  assign w_out_state = rst ? c_IDLE : r_state;

  // --------------------------------------------------------------------------
  // Next-state / round-robin bookkeeping
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last_served;
    case (r_state)
      c_IDLE: begin
        if (w_i_req && w_d_req) begin
          // Favour whichever client was not served most recently.
          w_state_nxt = (r_last_served == c_ICACHE) ? c_D_BUSY : c_I_BUSY;
        end else if (w_i_req) begin
          w_state_nxt = c_I_BUSY;
        end else if (w_d_req) begin
          w_state_nxt = c_D_BUSY;
        end
      end
      c_I_BUSY: begin
        if (pmem_resp) begin
          w_state_nxt = c_IDLE;
          w_last_nxt  = c_ICACHE;
        end
      end
      c_D_BUSY: begin
        // A finished transaction or an idle dcache releases the port unless
        // the dcache is holding it for a follow-on transaction.
        if ((pmem_resp || !w_d_req) && !hold_arbiter) begin
          w_state_nxt = c_IDLE;
          w_last_nxt  = c_DCACHE;
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= c_IDLE;
      r_last_served <= c_ICACHE;
    end else begin
      r_state       <= w_state_nxt;
      r_last_served <= w_last_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Combinational steering of commands and responses
  // --------------------------------------------------------------------------
  always_comb begin
    pmem_read         = 1'b0;
    pmem_write        = 1'b0;
    pmem_address      = '0;
    pmem_wdata        = '0;
    icache_pmem_rdata = '0;
    icache_pmem_resp  = 1'b0;
    dcache_pmem_rdata = '0;
    dcache_pmem_resp  = 1'b0;
    case (w_out_state)
      c_I_BUSY: begin
        pmem_read         = icache_pmem_read;
        pmem_address      = icache_pmem_address;
        icache_pmem_rdata = pmem_rdata;
        icache_pmem_resp  = pmem_resp;
      end
      c_D_BUSY: begin
        // If both commands are raised, the write takes precedence.
        pmem_write        = dcache_pmem_write;
        pmem_read         = dcache_pmem_read & ~dcache_pmem_write;
        pmem_address      = dcache_pmem_address;
        pmem_wdata        = dcache_pmem_wdata;
        dcache_pmem_rdata = pmem_rdata;
        dcache_pmem_resp  = pmem_resp;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter. Inputs change
//               1 ns after the rising edge and outputs are compared 1 ns later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int SIZE = 256;
  localparam int AW   = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            icache_pmem_read;
  logic [AW-1:0]   icache_pmem_address;
  logic [SIZE-1:0] icache_pmem_rdata;
  logic            icache_pmem_resp;
  logic            dcache_pmem_read;
  logic            dcache_pmem_write;
  logic [AW-1:0]   dcache_pmem_address;
  logic [SIZE-1:0] dcache_pmem_wdata;
  logic            hold_arbiter;
  logic [SIZE-1:0] dcache_pmem_rdata;
  logic            dcache_pmem_resp;
  logic            pmem_read;
  logic            pmem_write;
  logic [AW-1:0]   pmem_address;
  logic [SIZE-1:0] pmem_wdata;
  logic [SIZE-1:0] pmem_rdata;
  logic            pmem_resp;

  int errors = 0;
  int checks = 0;

  localparam logic [SIZE-1:0] c_A5 = {32{8'hA5}};
  localparam logic [SIZE-1:0] c_3C = {32{8'h3C}};
  localparam logic [SIZE-1:0] c_WD = {8{32'hDEADBEEF}};

  always #5 clk = ~clk;

  mem_arbiter #(.SIZE(SIZE), .ADDR_WIDTH(AW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .icache_pmem_resp    (icache_pmem_resp),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .hold_arbiter        (hold_arbiter),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .pmem_rdata          (pmem_rdata),
    .pmem_resp           (pmem_resp)
  );

  // advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    icache_pmem_read = 0; icache_pmem_address = '0;
    dcache_pmem_read = 0; dcache_pmem_write = 0; dcache_pmem_address = '0;
    dcache_pmem_wdata = '0; hold_arbiter = 0; pmem_rdata = '0; pmem_resp = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if ({pmem_read, pmem_write} !== 2'b00) begin errors++; $display("FAIL reset_cmd: got %b want 00", {pmem_read, pmem_write}); end
    checks++; if ({icache_pmem_resp, dcache_pmem_resp} !== 2'b00) begin errors++; $display("FAIL reset_resp: got %b want 00", {icache_pmem_resp, dcache_pmem_resp}); end
    checks++; if (pmem_address !== '0 || pmem_wdata !== '0) begin errors++; $display("FAIL reset_addr_wdata: got %h/%h want 0", pmem_address, pmem_wdata); end
    checks++; if (icache_pmem_rdata !== '0 || dcache_pmem_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0", icache_pmem_rdata, dcache_pmem_rdata); end
  endtask

  task automatic test_lone_icache();
    tick();
    icache_pmem_read = 1; icache_pmem_address = 32'h0000_1040;
    #1;
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL lone_arb_cycle: pmem_read got %b want 0", pmem_read); end
    tick();
    checks++; if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_1040) begin errors++; $display("FAIL lone_cmd: got rd=%b addr=%h want 1/00001040", pmem_read, pmem_address); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (icache_pmem_resp !== 1'b0 || pmem_read !== 1'b1) begin errors++; $display("FAIL lone_wait%0d: resp=%b rd=%b want 0/1", i, icache_pmem_resp, pmem_read); end
    end
    tick();
    pmem_resp = 1; pmem_rdata = c_A5;
    #1;
    checks++; if (icache_pmem_resp !== 1'b1 || icache_pmem_rdata !== c_A5) begin errors++; $display("FAIL lone_resp: resp=%b rdata=%h want 1/a5..", icache_pmem_resp, icache_pmem_rdata); end
    checks++; if (dcache_pmem_resp !== 1'b0) begin errors++; $display("FAIL lone_dresp: got %b want 0", dcache_pmem_resp); end
    tick();
    pmem_resp = 0; icache_pmem_read = 0;
    #1;
    checks++; if (icache_pmem_resp !== 1'b0 || pmem_read !== 1'b0) begin errors++; $display("FAIL lone_after: resp=%b rd=%b want 0/0", icache_pmem_resp, pmem_read); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    icache_pmem_read = 1; icache_pmem_address = 32'h100;
    dcache_pmem_read = 1; dcache_pmem_address = 32'h200;
    #1;
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL sim_idle: pmem_read got %b want 0", pmem_read); end
    tick();
    checks++; if (pmem_read !== 1'b1 || pmem_address !== 32'h200) begin errors++; $display("FAIL sim_first_d: rd=%b addr=%h want 1/200", pmem_read, pmem_address); end
    pmem_resp = 1; pmem_rdata = c_3C;
    #1;
    checks++; if (dcache_pmem_resp !== 1'b1 || icache_pmem_resp !== 1'b0 || dcache_pmem_rdata !== c_3C) begin errors++; $display("FAIL sim_dresp: d=%b i=%b want 1/0", dcache_pmem_resp, icache_pmem_resp); end
    tick();
    pmem_resp = 0; dcache_pmem_read = 0;
    #1;
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL sim_gap: pmem_read got %b want 0", pmem_read); end
    tick();
    checks++; if (pmem_read !== 1'b1 || pmem_address !== 32'h100) begin errors++; $display("FAIL sim_second_i: rd=%b addr=%h want 1/100", pmem_read, pmem_address); end
    pmem_resp = 1;
    #1;
    checks++; if (icache_pmem_resp !== 1'b1 || dcache_pmem_resp !== 1'b0) begin errors++; $display("FAIL sim_iresp: i=%b d=%b want 1/0", icache_pmem_resp, dcache_pmem_resp); end
    tick();
    pmem_resp = 0; icache_pmem_read = 0;
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] exp_addr;
    logic          exp_d;
    do_reset();
    icache_pmem_read = 1; icache_pmem_address = 32'h0A00;
    dcache_pmem_read = 1; dcache_pmem_address = 32'h0B00;
    for (int k = 0; k < 4; k++) begin
      exp_d    = (k % 2 == 0);
      exp_addr = exp_d ? 32'h0B00 : 32'h0A00;
      #1;
      checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL rr_idle%0d: pmem_read got %b want 0", k, pmem_read); end
      tick();
      checks++; if (pmem_read !== 1'b1 || pmem_address !== exp_addr) begin errors++; $display("FAIL rr_grant%0d: rd=%b addr=%h want 1/%h", k, pmem_read, pmem_address, exp_addr); end
      pmem_resp = 1;
      #1;
      checks++; if (dcache_pmem_resp !== exp_d || icache_pmem_resp !== !exp_d) begin errors++; $display("FAIL rr_resp%0d: d=%b i=%b want %b/%b", k, dcache_pmem_resp, icache_pmem_resp, exp_d, !exp_d); end
      tick();
      pmem_resp = 0;
    end
    icache_pmem_read = 0; dcache_pmem_read = 0;
    tick();
  endtask

  task automatic test_back_to_back_hold();
    icache_pmem_read = 1; icache_pmem_address = 32'h0111;
    dcache_pmem_write = 1; dcache_pmem_address = 32'h300; dcache_pmem_wdata = c_WD;
    hold_arbiter = 1;
    tick();
    checks++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 32'h300 || pmem_wdata !== c_WD) begin errors++; $display("FAIL hold_wb_cmd: wr=%b rd=%b addr=%h want 1/0/300", pmem_write, pmem_read, pmem_address); end
    tick();
    pmem_resp = 1;
    #1;
    checks++; if (dcache_pmem_resp !== 1'b1 || icache_pmem_resp !== 1'b0) begin errors++; $display("FAIL hold_wb_resp: d=%b i=%b want 1/0", dcache_pmem_resp, icache_pmem_resp); end
    tick();
    pmem_resp = 0; dcache_pmem_write = 0; dcache_pmem_read = 1;
    dcache_pmem_address = 32'h400; hold_arbiter = 0;
    #1;
    checks++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h400) begin errors++; $display("FAIL hold_refill_cmd: rd=%b wr=%b addr=%h want 1/0/400", pmem_read, pmem_write, pmem_address); end
    tick();
    checks++; if (pmem_address !== 32'h400 || icache_pmem_resp !== 1'b0) begin errors++; $display("FAIL hold_no_icache: addr=%h want 400", pmem_address); end
    pmem_resp = 1; pmem_rdata = c_A5;
    #1;
    checks++; if (dcache_pmem_resp !== 1'b1 || dcache_pmem_rdata !== c_A5) begin errors++; $display("FAIL hold_refill_resp: resp=%b rdata=%h want 1/a5..", dcache_pmem_resp, dcache_pmem_rdata); end
    tick();
    pmem_resp = 0; dcache_pmem_read = 0;
    #1;
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL hold_gap: pmem_read got %b want 0", pmem_read); end
    tick();
    checks++; if (pmem_read !== 1'b1 || pmem_address !== 32'h0111) begin errors++; $display("FAIL hold_icache_after: rd=%b addr=%h want 1/111", pmem_read, pmem_address); end
    pmem_resp = 1;
    #1;
    tick();
    pmem_resp = 0; icache_pmem_read = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    dcache_pmem_read = 1; dcache_pmem_address = 32'h600;
    tick();
    checks++; if (pmem_read !== 1'b1 || pmem_address !== 32'h600) begin errors++; $display("FAIL rmid_busy: rd=%b addr=%h want 1/600", pmem_read, pmem_address); end
    rst = 1; pmem_resp = 1;
    #1;
    checks++; if (dcache_pmem_resp !== 1'b0 || icache_pmem_resp !== 1'b0) begin errors++; $display("FAIL rmid_resp_in_reset: d=%b i=%b want 0/0", dcache_pmem_resp, icache_pmem_resp); end
    tick();
    rst = 0; dcache_pmem_read = 0;
    #1;
    checks++; if ({pmem_read, pmem_write} !== 2'b00) begin errors++; $display("FAIL rmid_cmd_drop: got %b want 00", {pmem_read, pmem_write}); end
    checks++; if (dcache_pmem_resp !== 1'b0 || icache_pmem_resp !== 1'b0) begin errors++; $display("FAIL rmid_late_resp: d=%b i=%b want 0/0", dcache_pmem_resp, icache_pmem_resp); end
    tick();
    pmem_resp = 0;
    #1;
    checks++; if ({pmem_read, pmem_write, dcache_pmem_resp} !== 3'b000) begin errors++; $display("FAIL rmid_idle: got %b want 000", {pmem_read, pmem_write, dcache_pmem_resp}); end
  endtask

  task automatic test_collision();
    dcache_pmem_read = 1; dcache_pmem_write = 1;
    dcache_pmem_address = 32'h500; dcache_pmem_wdata = c_3C;
    tick();
    checks++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin errors++; $display("FAIL coll_cmd: wr=%b rd=%b want 1/0", pmem_write, pmem_read); end
    checks++; if (pmem_wdata !== c_3C || pmem_address !== 32'h500) begin errors++; $display("FAIL coll_data: wdata=%h addr=%h want 3c../500", pmem_wdata, pmem_address); end
    pmem_resp = 1;
    #1;
    checks++; if (dcache_pmem_resp !== 1'b1) begin errors++; $display("FAIL coll_resp: got %b want 1", dcache_pmem_resp); end
    tick();
    pmem_resp = 0; dcache_pmem_read = 0; dcache_pmem_write = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_lone_icache();
    test_simultaneous();
    test_round_robin();
    test_back_to_back_hold();
    test_reset_mid();
    test_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
